// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, defaults and address check for the instruction memory responder
package imem_pkg;

  localparam int unsigned IMEM_DEPTH   = 256;
  localparam int unsigned IMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  // A byte address is usable when it is halfword aligned and its word index is inside the array.
  function automatic logic addr_ok(input logic [15:0] addr, input int unsigned depth);
    return (addr[0] == 1'b0) && ({17'd0, addr[15:1]} < depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - 16-bit word storage, synchronous write and combinational read
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [15:0]      rdata
);

  logic [15:0] mem [DEPTH];

  // Program preload port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - single-outstanding instruction fetch responder with fixed latency
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned LATENCY = IMEM_LATENCY,
  parameter int unsigned DEPTH   = IMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_err,
  input  logic        flush,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  LOAD_CNT = 3'(LATENCY - 1);

  imem_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] rd_word;
  logic        req_ok;
  logic        ld_ok;

  assign req_ok = addr_ok(req_addr, DEPTH);
  assign ld_ok  = addr_ok(load_addr, DEPTH);

  // The read path is combinational, so a same-edge load is seen only by later requests.
  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (load_en && ld_ok),
    .waddr (load_addr[IDX_W:1]),
    .wdata (load_data),
    .raddr (req_addr[IDX_W:1]),
    .rdata (rd_word)
  );

  // Next-state, latency counter, response capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = (state_q == ST_RESP);
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            data_d  = req_ok ? rd_word : 16'h0000;
            err_d   = !req_ok;
            cnt_d   = LOAD_CNT;
            state_d = (LATENCY <= 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and response registers; reset drops any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign resp_data = data_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder
module tb_imem_responder;

  localparam int LAT = 2;
  localparam int DEP = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        flush;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [DEP];

  imem_responder #(
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .flush      (flush),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [15:0] a);
    int idx;
    idx = int'(a[15:1]);
    return a[0] || (idx >= DEP);
  endfunction

  function automatic logic [15:0] exp_data(input logic [15:0] a);
    if (exp_err(a)) return 16'h0000;
    return model[int'(a[15:1])];
  endfunction

  // Advance one clock; the reference memory takes any legal load on the same edge.
  task automatic tick();
    logic do_ld;
    int   idx;
    idx   = int'(load_addr[15:1]);
    do_ld = load_en && !load_addr[0] && (idx < DEP);
    @(posedge clk);
    if (do_ld) model[idx] = load_data;
    #1;
  endtask

  task automatic do_req(input string tag, input logic [15:0] addr, input int hold,
                        input logic ld, input logic [15:0] ld_addr, input logic [15:0] ld_data,
                        input logic rand_ld);
    logic [15:0] ed;
    logic        ee;
    int          lat;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    ee         = exp_err(addr);
    ed         = exp_data(addr);
    req_valid  = 1'b1;
    req_addr   = addr;
    resp_ready = (hold == 0);
    load_en    = ld;
    load_addr  = ld_addr;
    load_data  = ld_data;
    tick();
    req_valid = 1'b0;
    load_en   = 1'b0;
    lat       = 1;
    while (!resp_valid && lat < 20) begin
      if (rand_ld) begin
        load_en   = 1'b1;
        load_addr = addr;
        load_data = 16'($urandom);
      end
      tick();
      load_en = 1'b0;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(LAT));
    check_eq({tag, "_data"}, 32'(resp_data), 32'(ed));
    check_eq({tag, "_err"}, 32'(resp_err), 32'(ee));
    for (int i = 1; i < hold; i++) begin
      if (rand_ld) begin
        load_en   = 1'b1;
        load_addr = addr;
        load_data = 16'($urandom);
      end
      tick();
      load_en = 1'b0;
      check_eq({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check_eq({tag, "_hold_data"}, 32'(resp_data), 32'(ed));
      check_eq({tag, "_hold_err"}, 32'(resp_err), 32'(ee));
      check_eq({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] a;
    int          kind;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 16'h0000;
    resp_ready = 1'b0;
    flush      = 1'b0;
    load_en    = 1'b0;
    load_addr  = 16'h0000;
    load_data  = 16'h0000;
    #1;
    check_eq("reset_valid", 32'(resp_valid), 32'd0);
    check_eq("reset_data", 32'(resp_data), 32'd0);
    check_eq("reset_err", 32'(resp_err), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("reset_ready", 32'(req_ready), 32'd1);

    // Preload every word, then the directed values; the odd and out-of-range loads must be ignored.
    for (int i = 0; i < DEP; i++) begin
      load_en   = 1'b1;
      load_addr = 16'(2 * i);
      load_data = 16'($urandom);
      tick();
    end
    load_addr = 16'h0006; load_data = 16'hA5C3; tick();
    load_addr = 16'h000A; load_data = 16'hFFFF; tick();
    load_addr = 16'h0007; load_data = 16'hDEAD; tick();
    load_addr = 16'h0200; load_data = 16'hBEEF; tick();
    load_en = 1'b0;

    do_req("aligned", 16'h0006, 0, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("word3_const", 32'(model[3]), 32'h0000A5C3);
    do_req("odd", 16'h0007, 0, 1'b0, 16'h0, 16'h0, 1'b0);
    do_req("range", 16'h0200, 0, 1'b0, 16'h0, 16'h0, 1'b0);
    do_req("stall", 16'h0006, 5, 1'b0, 16'h0, 16'h0, 1'b1);
    do_req("rbw_old", 16'h000A, 0, 1'b1, 16'h000A, 16'h1234, 1'b0);
    do_req("rbw_new", 16'h000A, 0, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("word5_const", 32'(model[5]), 32'h00001234);

    // Flush right after acceptance drops the request.
    req_valid = 1'b1;
    req_addr  = 16'h0006;
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    #1;
    check_eq("flush_ready", 32'(req_ready), 32'd0);
    tick();
    flush      = 1'b0;
    resp_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (resp_valid) seen++;
        tick();
      end
      check_eq("flush_no_resp", 32'(seen), 32'd0);
    end
    resp_ready = 1'b0;
    do_req("after_flush", 16'h0000, 0, 1'b0, 16'h0, 16'h0, 1'b0);

    // Reset while waiting discards the request.
    req_valid = 1'b1;
    req_addr  = 16'h0006;
    tick();
    req_valid = 1'b0;
    rst       = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_data", 32'(resp_data), 32'd0);
    check_eq("midrst_err", 32'(resp_err), 32'd0);
    tick();
    rst        = 1'b1;
    resp_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (resp_valid) seen++;
        tick();
      end
      check_eq("midrst_no_resp", 32'(seen), 32'd0);
    end
    resp_ready = 1'b0;
    check_eq("midrst_ready", 32'(req_ready), 32'd1);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      a    = 16'($urandom);
      case (kind)
        0:       a = {a[15:9], 9'h000} | 16'h0001;
        1:       a = 16'h0200 + {a[14:0], 1'b0};
        default: a = {7'h00, a[8:1], 1'b0};
      endcase
      if (a < 16'h0200 && kind == 1) a = 16'h0400;
      do_req("random", a, int'($urandom_range(0, 3)), 1'($urandom),
             {7'h00, 8'($urandom), 1'b0}, 16'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to resp_valid (legal 1..7).
REQ-002 Parameter DEPTH, default 256, number of 16-bit instruction words stored.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  fetch unit presents a read request.
REQ-006 req_addr  input  16  byte address of the instruction (PC value).
REQ-007 req_ready  output  1  responder accepts the request this cycle.
REQ-008 resp_valid  output  1  resp_data/resp_err are valid.
REQ-009 resp_ready  input  1  fetch unit consumes the response this cycle.
REQ-010 resp_data  output  16  instruction word read.
REQ-011 resp_err  output  1  request was misaligned or out of range.
REQ-012 flush  input  1  abandon any outstanding request (branch/jump redirect).
REQ-013 load_en  input  1  write one word into the array (program preload).
REQ-014 load_addr  input  16  byte address for load.
REQ-015 load_data  input  16  word written when load_en is high.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; reset state is IDLE.
REQ-017 req_ready is 1 only in IDLE with flush low; a request is accepted when req_valid and req_ready are both 1.
REQ-018 On acceptance: the addressed word is captured into the data register that cycle; the latency counter is loaded with LATENCY-1; the FSM goes to WAIT, or to RESP directly if LATENCY=1.
REQ-019 WAIT: the counter decrements each cycle; when it reaches 0 the FSM moves to RESP.
REQ-020 RESP: resp_valid is 1; resp_data and resp_err stay stable until resp_ready is 1.
REQ-021 When resp_ready is 1 in RESP, the FSM returns to IDLE; the next request is accepted one cycle later at the earliest (at most one outstanding request).
REQ-022 Word index is req_addr[15:1]; req_addr[0]=1 sets resp_err=1 and resp_data=16'h0000.
REQ-023 A word index >= DEPTH sets resp_err=1 and resp_data=16'h0000.
REQ-024 flush high in any state forces IDLE next cycle; no response is produced for the dropped request, and req_ready is 0 during the flush cycle.
REQ-025 load_en writes load_data at index load_addr[15:1] on the clock edge; out-of-range or odd load addresses are ignored.
REQ-026 Load and acceptance to the same word in the same cycle: the response returns the old contents (read-before-write).
REQ-027 A load during WAIT/RESP to an already-captured address does not alter the pending response.
REQ-028 resp_valid is 0 in IDLE and WAIT.

Reset
REQ-029 Asserting rst immediately forces IDLE, clears the counter, and sets resp_valid=0, resp_err=0, resp_data=16'h0000, req_ready=1 (once released).
REQ-030 Array contents are not reset; a reset mid-request discards that request with no response.

Structure
REQ-031 FSM state encodings and the DEPTH/LATENCY defaults reside in the shared imem package.
REQ-032 Storage is one sub-module, imem_array (synchronous write, combinational read, 16-bit words).
REQ-033 The FSM, counter and response register reside in imem_responder; the design contains no other sub-modules.

Verification
REQ-034 Preload word 3 = 16'hA5C3; request addr 16'h0006 with resp_ready=1 -> resp_valid exactly 2 cycles after acceptance, data A5C3, err 0.
REQ-035 Request addr 16'h0007 -> resp_err=1, resp_data=16'h0000, after LATENCY cycles.
REQ-036 Request addr 16'h0200 (index 256) -> resp_err=1, resp_data=16'h0000.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable throughout, req_ready=0; release -> IDLE, req_ready=1 the next cycle.
REQ-038 Assert flush in the cycle after acceptance -> no resp_valid ever appears for that request; a new request 16'h0000 two cycles later returns word 0.
REQ-039 Same cycle: load word 5 = 16'h1234 and accept request 16'h000A, old value 16'hFFFF -> response FFFF; a following request to 16'h000A -> 1234.
